// File: rtl/mem_burst_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_burst_read_arbiter
//
// Purpose:
//   Round-robin arbiter for NUM_CH burst-read requesters that share one
//   single-port memory. Each grant runs one SETUP cycle followed by a
//   BURST_LEN-beat read burst. The block drives the chip enable and the
//   address, and flags the first and last beats. Every channel has its own
//   wrapping read pointer, which advances by BURST_LEN after each burst.
//   All outputs are registered, so there is no combinational path from req.
//
// Ports:
//   clk    in   1        clock, all state changes on the rising edge
//   rst_n  in   1        asynchronous active-low reset
//   req    in   NUM_CH   per-channel burst request (level, sampled in IDLE)
//   gnt    out  NUM_CH   one-hot grant, held from SETUP through the last beat
//   ch_id  out  CH_W     binary index of the granted channel (valid while busy)
//   busy   out  1        high in SETUP and BURST
//   cen    out  1        memory chip enable, high in SETUP and BURST
//   start  out  1        high on the first burst beat only
//   last   out  1        high on the final burst beat only
//   addr   out  ADDR_W   memory address (holds its last value while idle)
// -----------------------------------------------------------------------------
module mem_burst_read_arbiter #(
    parameter  int ADDR_W    = 10,
    parameter  int BURST_LEN = 4,
    parameter  int NUM_CH    = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   ch_id,
    output logic              busy,
    output logic              cen,
    output logic              start,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_CH-1:0]   r_gnt;
    logic [CH_W-1:0]     r_ch_id;
    logic                r_busy;
    logic                r_cen;
    logic                r_start;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [BEAT_W-1:0]   r_beat;
    logic [CH_W-1:0]     r_prev;   // winner of the most recent burst
    logic [ADDR_W-1:0]   r_ptr [NUM_CH];

    logic [CH_W-1:0]     w_win;
    logic                w_found;

    // Round-robin pick: first set request searching upward from the channel
    // after the previous winner, wrapping modulo NUM_CH.
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_found && req[(int'(r_prev) + i) % NUM_CH]) begin
                w_win   = CH_W'((int'(r_prev) + i) % NUM_CH);
                w_found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and update order does not matter.
    // NOTE: the per-channel pointer array is small flop storage rather than a
    // RAM macro, and it must come out of reset at zero, so it is reset here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ch_id <= '0;
            r_busy  <= 1'b0;
            r_cen   <= 1'b0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_beat  <= '0;
            // Previous winner = last channel, so channel 0 wins the first tie.
            r_prev  <= CH_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                r_ptr[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= NUM_CH'(1) << w_win;
                        r_ch_id <= w_win;
                        r_busy  <= 1'b1;
                        r_cen   <= 1'b1;
                        r_addr  <= r_ptr[w_win];
                        r_state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // The address already points at beat 0. Only start rises.
                    r_start <= 1'b1;
                    r_last  <= 1'b0;
                    r_beat  <= '0;
                    r_state <= ST_BURST;
                end

                ST_BURST: begin
                    if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                        // End of the burst: commit the pointer and drop to IDLE.
                        // addr keeps the final beat address.
                        r_ptr[r_ch_id] <= r_ptr[r_ch_id] + ADDR_W'(BURST_LEN);
                        r_prev  <= r_ch_id;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_cen   <= 1'b0;
                        r_start <= 1'b0;
                        r_last  <= 1'b0;
                        r_beat  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        // A power-of-two burst starts on an aligned address,
                        // so this increment never crosses the wrap point
                        // in the middle of a burst.
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_beat  <= r_beat + BEAT_W'(1);
                        r_start <= 1'b0;
                        r_last  <= (r_beat == BEAT_W'(BURST_LEN - 2));
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign ch_id = r_ch_id;
    assign busy  = r_busy;
    assign cen   = r_cen;
    assign start = r_start;
    assign last  = r_last;
    assign addr  = r_addr;

endmodule
